// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a req/ack data-memory handshake,
// load/store lane formatting, an access timeout and an optional misalign trap.
// Ports: clk, rst (sync, active-high); ex_* inputs captured into stage
// register M; mem_stall holds EX upstream; dmem_* is the data-memory port
// (word address, byte strobes, replicated store data, ack/rdata); wb_* are
// the registered write-back outputs; mem_bus_err / mem_misalign pulse
// together with wb_valid.
// Build macro: MEM_MISALIGN_TRAP_EN turns misaligned LH/LHU/SH/LW/SW into
// a trap that completes without a memory access.
module mem_stage #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_rs2_data,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_mem_reg,
   input  logic [31:0] ex_mem_instruction,
   output logic        mem_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        mem_bus_err,
   output logic        mem_misalign
);

   localparam logic [7:0] WaitMax = 8'(MAX_WAIT);

   typedef struct packed {
      logic        valid;
      logic [31:0] alu;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_reg;
      logic [2:0]  funct3;
   } m_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   m_t          m_q, m_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        wb_valid_q, wb_valid_d;
   logic        wb_rw_q, wb_rw_d;
   logic [4:0]  wb_rd_q;
   logic [31:0] wb_data_q, wb_data_d;
   logic        bus_err_q, bus_err_d;
   logic        mis_q, mis_d;

   logic        in_wait;
   logic        timeout;
   logic        mem_op_ex;
   logic        go_wait;
   logic        mis_ex;
   logic        mis_m;
   logic        done_ok;
   logic        abort;
   logic        idle_done;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] ld_data;
   logic [3:0]  st_strb;
   logic [31:0] st_data;
   logic        unused_instr;

   // Only funct3 of the instruction word matters here.
   assign unused_instr = ^{ex_mem_instruction[31:15],
                           ex_mem_instruction[11:0]};

   assign mem_op_ex = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
   function automatic logic misal(input logic [2:0] f3,
                                  input logic [1:0] a,
                                  input logic       rd_op);
      logic half;
      logic word;
      half = (f3 == 3'b001) | ((f3 == 3'b101) & rd_op);
      word = (f3 == 3'b010);
      return (half & a[0]) | (word & (a != 2'b00));
   endfunction

   assign mis_ex = mem_op_ex
                 & misal(ex_mem_instruction[14:12],
                         ex_alu_result[1:0], ex_mem_read);
   assign mis_m  = m_q.valid & (m_q.mem_read | m_q.mem_write)
                 & misal(m_q.funct3, m_q.alu[1:0], m_q.mem_read);
`else
   assign mis_ex = 1'b0;
   assign mis_m  = 1'b0;
`endif

   // A trapped misaligned access stays in IDLE and retires like an ALU op.
   assign go_wait = mem_op_ex & ~mis_ex;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state; every non-stalled edge captures, so the new
   // instruction alone decides where we go (back-to-back on ack).
   always_comb begin
      state_d = state_q;
      if (!mem_stall) begin
         state_d = go_wait ? S_WAIT : S_IDLE;
      end
   end

   // FSM: outputs
   always_comb begin
      in_wait   = (state_q == S_WAIT);
      dmem_req  = in_wait;
      timeout   = in_wait & (cnt_q == WaitMax);
      mem_stall = in_wait & ~dmem_ack & ~timeout;
   end

   // Stage register M
   always_comb begin
      m_d = m_q;
      if (!mem_stall) begin
         m_d = '0;
         if (ex_valid) begin
            m_d.valid     = 1'b1;
            m_d.alu       = ex_alu_result;
            m_d.rs2       = ex_rs2_data;
            m_d.rd        = ex_rd;
            m_d.reg_write = ex_reg_write;
            m_d.mem_read  = ex_mem_read;
            m_d.mem_write = ex_mem_write;
            m_d.mem_reg   = ex_mem_reg;
            m_d.funct3    = ex_mem_instruction[14:12];
         end
      end
   end

   assign cnt_d = mem_stall ? cnt_q + 8'd1 : 8'd0;

   // Load lane selection; halfwords ignore addr[0].
   always_comb begin
      ld_b = 8'(dmem_rdata >> {m_q.alu[1:0], 3'b000});
      ld_h = 16'(dmem_rdata >> {m_q.alu[1], 4'b0000});
      case (m_q.funct3)
         3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
         3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
         3'b100:  ld_data = {24'd0, ld_b};
         3'b101:  ld_data = {16'd0, ld_h};
         default: ld_data = dmem_rdata;
      endcase
   end

   // Store strobes and lane-replicated data.
   always_comb begin
      case (m_q.funct3[1:0])
         2'b00: begin
            st_strb = 4'b0001 << m_q.alu[1:0];
            st_data = {4{m_q.rs2[7:0]}};
         end
         2'b01: begin
            st_strb = 4'b0011 << {m_q.alu[1], 1'b0};
            st_data = {2{m_q.rs2[15:0]}};
         end
         default: begin
            st_strb = 4'b1111;
            st_data = m_q.rs2;
         end
      endcase
   end

   assign dmem_we    = m_q.mem_write;
   assign dmem_addr  = {m_q.alu[31:2], 2'b00};
   assign dmem_wdata = st_data;
   assign dmem_wstrb = m_q.mem_write ? st_strb : 4'b0000;

   // Completion sources
   assign done_ok   = in_wait & dmem_ack;
   assign abort     = in_wait & ~dmem_ack & timeout;
   assign idle_done = ~in_wait & m_q.valid;

   always_comb begin
      wb_valid_d = done_ok | abort | idle_done;
      wb_rw_d    = (done_ok | (idle_done & ~mis_m))
                 & m_q.reg_write & (m_q.rd != 5'd0);
      wb_data_d  = m_q.mem_reg ? ld_data : m_q.alu;
      bus_err_d  = abort;
      mis_d      = idle_done & mis_m;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_q        <= '0;
         cnt_q      <= 8'd0;
         wb_valid_q <= 1'b0;
         wb_rw_q    <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
         bus_err_q  <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         m_q        <= m_d;
         cnt_q      <= cnt_d;
         wb_valid_q <= wb_valid_d;
         wb_rw_q    <= wb_rw_d;
         bus_err_q  <= bus_err_d;
         mis_q      <= mis_d;
         if (wb_valid_d) begin
            wb_rd_q   <= m_q.rd;
            wb_data_q <= wb_data_d;
         end
      end
   end

   assign wb_valid     = wb_valid_q;
   assign wb_reg_write = wb_rw_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign mem_bus_err  = bus_err_q;
   assign mem_misalign = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage with a transaction-level
// reference model, a memory responder and a write-back scoreboard.
module tb_mem_stage;

   localparam int MW = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_rs2_data;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_mem_reg;
   logic [31:0] ex_mem_instruction;
   logic        mem_stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mem_bus_err;
   logic        mem_misalign;

   always #5 clk = ~clk;

   mem_stage #(.MAX_WAIT(MW)) dut (
      .clk               (clk),
      .rst               (rst),
      .ex_valid          (ex_valid),
      .ex_alu_result     (ex_alu_result),
      .ex_rs2_data       (ex_rs2_data),
      .ex_rd             (ex_rd),
      .ex_reg_write      (ex_reg_write),
      .ex_mem_read       (ex_mem_read),
      .ex_mem_write      (ex_mem_write),
      .ex_mem_reg        (ex_mem_reg),
      .ex_mem_instruction(ex_mem_instruction),
      .mem_stall         (mem_stall),
      .dmem_req          (dmem_req),
      .dmem_we           (dmem_we),
      .dmem_addr         (dmem_addr),
      .dmem_wdata        (dmem_wdata),
      .dmem_wstrb        (dmem_wstrb),
      .dmem_ack          (dmem_ack),
      .dmem_rdata        (dmem_rdata),
      .wb_valid          (wb_valid),
      .wb_reg_write      (wb_reg_write),
      .wb_rd             (wb_rd),
      .wb_data           (wb_data),
      .mem_bus_err       (mem_bus_err),
      .mem_misalign      (mem_misalign)
   );

   // dly: WAIT cycles up to and including the ack cycle; 0 = never ack.
   typedef struct {
      logic        v;
      logic [31:0] alu;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        mreg;
      int          dly;
      logic [31:0] rdata;
   } stim_t;

   typedef struct {
      int          due;
      logic [4:0]  rd;
      logic        rw;
      logic        chk;
      logic [31:0] data;
      logic        err;
      logic        mis;
   } wb_t;

   typedef struct {
      int          start;
      int          fin;
      logic        acks;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  strb;
   } mem_t;

   stim_t stimq[$];
   wb_t   wbq[$];
   mem_t  memq[$];

   int    n_chk = 0;
   int    n_err = 0;
   int    it = 0;
   int    nrand;
   bit    have;
   bit    exp_stall;
   stim_t cur;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (it %0d)",
                  tag, got, exp, it);
      end
   endtask

   function automatic stim_t mk(input logic v, input logic [31:0] alu,
                                input logic [31:0] rs2,
                                input logic [4:0] rd,
                                input logic [2:0] f3, input logic rw,
                                input logic mr, input logic mw,
                                input logic mreg, input int dly,
                                input logic [31:0] rdata);
      stim_t s;
      s.v = v; s.alu = alu; s.rs2 = rs2; s.rd = rd; s.f3 = f3;
      s.rw = rw; s.mr = mr; s.mw = mw; s.mreg = mreg;
      s.dly = dly; s.rdata = rdata;
      return s;
   endfunction

   function automatic stim_t rnd();
      stim_t s;
      int    k;
      int    sel;
      k = $urandom_range(0, 9);
      s = mk(1'b1, $urandom, $urandom, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0,
             1'b0, $urandom_range(2, 5), $urandom);
      s.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 29) == 0) s.dly = 0;
      if (k == 0) begin
         s.v  = 1'b0;
         s.mr = 1'($urandom);
         s.rw = 1'b1;
      end else if (k <= 3) begin
         s.rw = 1'($urandom);
      end else if (k <= 6) begin
         s.mr = 1'b1; s.rw = 1'b1; s.mreg = 1'b1;
         sel = $urandom_range(0, 6);
         case (sel)
            0: s.f3 = 3'd0;
            1: s.f3 = 3'd1;
            2: s.f3 = 3'd2;
            3: s.f3 = 3'd4;
            4: s.f3 = 3'd5;
            5: s.f3 = 3'd3;
            default: s.f3 = 3'd6;
         endcase
      end else begin
         s.mw = 1'b1;
         s.f3 = 3'($urandom_range(0, 2));
      end
      return s;
   endfunction

   function automatic logic [31:0] ld_fmt(input logic [31:0] w,
                                          input logic [31:0] a,
                                          input logic [2:0] f3);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * (a % 4))) % 256;
      h = (w >> (16 * ((a / 2) % 2))) % 65536;
      case (f3)
         3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] st_strb(input logic [31:0] a,
                                          input logic [2:0] f3);
      case (f3)
         3'd0:    return 4'(1 << (a % 4));
         3'd1:    return 4'(3 << (2 * ((a / 2) % 2)));
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] st_data(input logic [31:0] d,
                                           input logic [2:0] f3);
      case (f3)
         3'd0:    return (d % 256) * 32'h0101_0101;
         3'd1:    return (d % 65536) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

`ifdef MEM_MISALIGN_TRAP_EN
   function automatic logic is_misal(input logic [2:0] f3,
                                     input logic [31:0] a,
                                     input logic mr);
      if (f3 == 3'd1 || (f3 == 3'd5 && mr)) return (a % 2) != 0;
      if (f3 == 3'd2) return (a % 4) != 0;
      return 1'b0;
   endfunction
`endif

   task automatic drive(input stim_t s);
      logic [31:0] ins;
      ins = $urandom;
      ins[14:12] = s.f3;
      ex_valid = s.v;
      ex_alu_result = s.alu;
      ex_rs2_data = s.rs2;
      ex_rd = s.rd;
      ex_reg_write = s.rw;
      ex_mem_read = s.mr;
      ex_mem_write = s.mw;
      ex_mem_reg = s.mreg;
      ex_mem_instruction = ins;
   endtask

   // Model of one captured instruction: its write-back and, for memory
   // ops, the request the responder should see.
   task automatic push_exp(input stim_t s);
      wb_t  w;
      mem_t m;
      logic mis;
      w.due = it + 2;
      w.rd = s.rd;
      w.rw = s.rw && (s.rd != 5'd0);
      w.chk = 1'b1;
      w.err = 1'b0;
      w.mis = 1'b0;
      w.data = s.mreg ? ld_fmt(s.rdata, s.alu, s.f3) : s.alu;
      if (s.mr || s.mw) begin
         mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         mis = is_misal(s.f3, s.alu, s.mr);
`endif
         if (mis) begin
            w.mis = 1'b1; w.rw = 1'b0; w.chk = 1'b0;
         end else begin
            m.start = it + 1;
            m.addr = s.alu & 32'hFFFF_FFFC;
            m.we = s.mw;
            m.strb = st_strb(s.alu, s.f3);
            m.wdata = st_data(s.rs2, s.f3);
            m.rdata = s.rdata;
            if (s.dly == 0) begin
               m.acks = 1'b0;
               m.fin = m.start + MW;
               w.err = 1'b1; w.rw = 1'b0; w.chk = 1'b0;
            end else begin
               m.acks = 1'b1;
               m.fin = m.start + s.dly - 1;
            end
            w.due = m.fin + 1;
            memq.push_back(m);
         end
      end
      wbq.push_back(w);
   endtask

   initial begin
      stim_t bub;
      bub = mk(1'b0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,
               2, 32'd0);
      rst = 1'b1;
      drive(bub);
      dmem_ack = 1'b0;
      dmem_rdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_rw", 32'(wb_reg_write), 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_bus_err", 32'(mem_bus_err), 32'd0);
      chk("rst_misalign", 32'(mem_misalign), 32'd0);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(mem_stall), 32'd0);
      rst = 1'b0;

      stimq.push_back(mk(1, 32'h100, 32'h0, 5'd5, 3'd2, 1, 1, 0, 1,
                         2, 32'hDEAD_BEEF));
      stimq.push_back(mk(1, 32'h103, 32'h0, 5'd6, 3'd0, 1, 1, 0, 1,
                         2, 32'h80FF_FFFF));
      stimq.push_back(mk(1, 32'h103, 32'h0, 5'd7, 3'd4, 1, 1, 0, 1,
                         2, 32'h80FF_FFFF));
      stimq.push_back(mk(1, 32'h102, 32'h1234_ABCD, 5'd1, 3'd1, 0, 0, 1,
                         0, 2, 32'h0));
      stimq.push_back(mk(1, 32'h104, 32'h0, 5'd8, 3'd2, 1, 1, 0, 1,
                         0, 32'h0));
      stimq.push_back(mk(1, 32'd7, 32'h0, 5'd0, 3'd0, 1, 0, 0, 0,
                         2, 32'h0));
      stimq.push_back(mk(1, 32'd9, 32'h0, 5'd3, 3'd0, 1, 0, 0, 0,
                         2, 32'h0));
      stimq.push_back(mk(1, 32'h108, 32'h0, 5'd9, 3'd2, 1, 1, 0, 1,
                         MW + 1, 32'h1122_3344));
      stimq.push_back(mk(1, 32'h102, 32'h0, 5'd10, 3'd2, 1, 1, 0, 1,
                         2, 32'hCAFE_F00D));
      stimq.push_back(mk(1, 32'h101, 32'h0, 5'd11, 3'd1, 1, 1, 0, 1,
                         3, 32'h89AB_7654));
      nrand = 400;
      have = 1'b0;

      while (!(nrand == 0 && stimq.size() == 0 && !have &&
               memq.size() == 0 && wbq.size() == 0)) begin
         @(negedge clk);
         it++;
         if (it > 20000) begin
            n_chk++;
            n_err++;
            $display("FAIL loop_bound: got %0d expected <= 20000", it);
            break;
         end
         // write-back scoreboard
         if (wbq.size() > 0 && wbq[0].due == it) begin
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("wb_reg_write", 32'(wb_reg_write), 32'(wbq[0].rw));
            chk("wb_bus_err", 32'(mem_bus_err), 32'(wbq[0].err));
            chk("wb_misalign", 32'(mem_misalign), 32'(wbq[0].mis));
            if (wbq[0].chk) begin
               chk("wb_rd", 32'(wb_rd), 32'(wbq[0].rd));
               chk("wb_data", wb_data, wbq[0].data);
            end
            void'(wbq.pop_front());
         end else begin
            chk("wb_idle_valid", 32'(wb_valid), 32'd0);
            chk("wb_idle_err", 32'(mem_bus_err), 32'd0);
            chk("wb_idle_mis", 32'(mem_misalign), 32'd0);
         end
         // memory responder
         if (memq.size() > 0 && memq[0].start <= it) begin
            chk("req", 32'(dmem_req), 32'd1);
            chk("addr", dmem_addr, memq[0].addr);
            chk("we", 32'(dmem_we), 32'(memq[0].we));
            if (memq[0].we) begin
               chk("wstrb", 32'(dmem_wstrb), 32'(memq[0].strb));
               chk("wdata", dmem_wdata, memq[0].wdata);
            end
            dmem_ack = memq[0].acks && (it == memq[0].fin);
            dmem_rdata = dmem_ack ? memq[0].rdata : $urandom;
            exp_stall = (it != memq[0].fin);
            if (it == memq[0].fin) void'(memq.pop_front());
         end else begin
            chk("req_idle", 32'(dmem_req), 32'd0);
            dmem_ack = ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
            exp_stall = 1'b0;
         end
         // instruction driver
         if (!have) begin
            if (stimq.size() > 0) cur = stimq.pop_front();
            else if (nrand > 0) begin
               cur = rnd();
               nrand--;
            end else cur = bub;
            have = 1'b1;
            drive(cur);
         end
         #1;
         chk("stall", 32'(mem_stall), 32'(exp_stall));
         if (!exp_stall) begin
            if (cur.v) push_exp(cur);
            have = 1'b0;
         end
      end

      // Reset while an access is outstanding.
      @(negedge clk);
      dmem_ack = 1'b0;
      drive(mk(1, 32'h200, 32'h0, 5'd4, 3'd2, 1, 1, 0, 1, 0, 32'h0));
      #1;
      chk("rw_capture_stall", 32'(mem_stall), 32'd0);
      @(negedge clk);
      drive(bub);
      chk("rw_req", 32'(dmem_req), 32'd1);
      #1;
      chk("rw_stall", 32'(mem_stall), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rw_req_after_rst", 32'(dmem_req), 32'd0);
      chk("rw_wb_after_rst", 32'(wb_valid), 32'd0);
      dmem_ack = 1'b1;
      dmem_rdata = 32'h5555_AAAA;
      #1;
      chk("rw_stall_after_rst", 32'(mem_stall), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rw_late_ack_wb", 32'(wb_valid), 32'd0);
         chk("rw_late_ack_req", 32'(dmem_req), 32'd0);
      end
      dmem_ack = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: MAX_WAIT, 16, cycles dmem_req may stay high without dmem_ack before the access is aborted (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ex_valid  input  1  EX outputs carry a real instruction; low means bubble.
REQ-005 ex_alu_result  input  32  ALU result; effective address for loads and stores.
REQ-006 ex_rs2_data  input  32  store data.
REQ-007 ex_rd  input  5  destination register.
REQ-008 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_reg  input  1 each  control flags from EX.
REQ-009 ex_mem_instruction  input  32  instruction; bits [14:12] are funct3.
REQ-010 mem_stall  output  1  upstream holds EX while high.
REQ-011 dmem_req, dmem_we  output  1 each  data-memory request and write enable.
REQ-012 dmem_addr  output  32  word address: effective address with bits [1:0] = 0.
REQ-013 dmem_wdata  output  32; dmem_wstrb  output  4  store data and byte strobes.
REQ-014 dmem_ack  input  1; dmem_rdata  input  32  access completion and read data, valid when dmem_ack = 1.
REQ-015 wb_valid, wb_reg_write  output  1 each; wb_rd  output  5; wb_data  output  32  registered MEM/WB outputs.
REQ-016 mem_bus_err, mem_misalign  output  1 each  one-cycle flags, asserted together with wb_valid.

Function
REQ-017 Stage register M SHALL capture all ex_* inputs on every edge where mem_stall = 0; a capture with ex_valid = 0 SHALL load a bubble.
REQ-018 FSM states SHALL be IDLE and WAIT; a capture of a valid memory operation (mem_read or mem_write) SHALL move to WAIT on the same edge.
REQ-019 dmem_req SHALL equal (state == WAIT); while WAIT, dmem_addr, dmem_we (= M.mem_write), dmem_wdata and dmem_wstrb SHALL be stable.
REQ-020 mem_stall SHALL equal (state == WAIT) & ~dmem_ack & ~timeout, which allows back-to-back capture on the completing edge.
REQ-021 A non-memory M SHALL complete in IDLE: wb_* SHALL be written at the next edge, giving 1-cycle latency from capture.
REQ-022 A memory access SHALL complete on the edge where dmem_ack = 1 in WAIT: wb_* SHALL be written, state SHALL return to IDLE, and minimum load latency SHALL be 2 cycles from capture.
REQ-023 dmem_ack in IDLE SHALL be ignored.
REQ-024 Load formatting SHALL use lane = addr[1:0] and funct3: 000 LB sign-extended, 001 LH sign-extended, 010 LW, 100 LBU zero-extended, 101 LHU zero-extended; other codes SHALL return the full word.
REQ-025 Store strobes: SB = 0001 << addr[1:0]; SH = 0011 << {addr[1],0}; SW = 1111.
REQ-026 Store wdata SHALL replicate the byte (SB) or halfword (SH) across all lanes.
REQ-027 wb_data SHALL be the formatted load data when M.mem_reg = 1, otherwise M.alu_result.
REQ-028 wb_reg_write SHALL be M.reg_write & (M.rd != 0); wb_valid SHALL be 0 for bubbles.
REQ-029 A wait counter SHALL count WAIT cycles without ack.
REQ-030 When the counter reaches MAX_WAIT, timeout SHALL abort the access: return to IDLE, wb_valid = 1, wb_reg_write = 0, mem_bus_err = 1 for one cycle.
REQ-031 If dmem_ack and timeout coincide, the ack SHALL win.

Reset
REQ-032 On an rst edge: state = IDLE, M = bubble, counter = 0, and wb_valid, wb_reg_write, wb_rd, wb_data, mem_bus_err and mem_misalign = 0.
REQ-033 Consequently dmem_req = 0 and mem_stall = 0 from the cycle after reset.
REQ-034 Reset in WAIT SHALL abandon the access with no write-back; a late dmem_ack SHALL be ignored.

Configuration
REQ-035 Macro MEM_MISALIGN_TRAP_EN.
REQ-036 When defined: an LH/LHU/SH with addr[0] = 1, or an LW/SW with addr[1:0] != 0, SHALL NOT enter WAIT; it SHALL complete like a non-memory op with wb_reg_write = 0 and mem_misalign = 1.
REQ-037 When undefined: the access proceeds, word accesses ignore addr[1:0], halfword accesses ignore addr[0], and mem_misalign is tied 0.

Verification
REQ-038 LW addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF, rd 5 -> wb_data 0xDEADBEEF, wb_rd 5, wb_reg_write 1, 2 cycles after capture.
REQ-039 LB addr 0x103, rdata 0x80FFFFFF -> wb_data 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-040 SH addr 0x102, rs2 0x1234ABCD -> dmem_wstrb 1100, dmem_wdata 0xABCDABCD, dmem_addr 0x100, wb_reg_write 0.
REQ-041 Load with no ack, MAX_WAIT 16 -> mem_stall high for 16 cycles, then mem_bus_err pulse, wb_reg_write 0, dmem_req low.
REQ-042 ADD (rd 0, alu 7) then ADD (rd 3, alu 9) back-to-back -> second wb has wb_reg_write 1 and wb_data 9, first has wb_reg_write 0; also rst asserted during WAIT -> dmem_req 0 next cycle and no wb_valid.
REQ-043 With MEM_MISALIGN_TRAP_EN, LW addr 0x102 -> no dmem_req, mem_misalign 1, wb_reg_write 0.
